abm_sched: RTL and testbench

Schedules transfers on the ABM-to-PCIe block mover: counts "frame ready" events from the acquisition side and issues one mover kick per frame. Each kick targets the next slot of a host-side ring of destination buffers. Sits between the frame producer, the AXI-Lite config registers (base, stride, ring size) and the mover's `start`/`dst_address`/`idle` handshake. It also reports progress and error status back to the register file.

---
 rtl/abm_sched.sv | 192 +++++++++++++++++++
 tb/tb_abm_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abm_sched.sv
// -----------------------------------------------------------------------------
// abm_sched -- frame-to-mover transfer scheduler for the ABM-to-PCIe block mover
//
// Counts "frame ready" pulses from the acquisition side and issues one mover
// kick per frame. Each kick targets the next slot of a host-side ring of
// destination buffers (base_addr + slot_index * stride). Progress and error
// status are reported back to the register file.
//
// Optional feature macro: ABM_SCHED_TIMEOUT_EN
//   defined   -> a watchdog counts cycles spent in S_WAIT_BUSY + S_WAIT_IDLE;
//                on reaching TIMEOUT_CYCLES the transfer is abandoned, timeout
//                is set and the FSM returns to S_IDLE.
//   undefined -> no watchdog logic; timeout is tied 0 and the FSM waits forever.
//
// Parameters:
//   RING_W          width of ring slot index (ring holds up to 2^RING_W slots)
//   PEND_W          width of pending-frame counter (saturates at 2^PEND_W-1)
//   TIMEOUT_CYCLES  watchdog limit, only used with ABM_SCHED_TIMEOUT_EN
//
// Ports:
//   clk                in   sole clock
//   reset              in   synchronous, active-high reset
//   enable             in   level; 0 = issue no new kicks
//   base_addr          in   host address of ring slot 0; 0 = ring not configured
//   stride             in   bytes between consecutive slots
//   ring_slots         in   number of slots, 1..2^RING_W (0 treated as 1)
//   frame_ready        in   one-cycle pulse per completed frame
//   mover_start        out  one-cycle kick to the mover
//   mover_dst_address  out  destination of the current kick, held until next kick
//   mover_idle         in   mover idle status
//   slot_index         out  slot the next kick will use
//   frames_done        out  completed transfers, wraps modulo 2^32
//   pending            out  frames not yet kicked
//   busy               out  FSM is not in S_IDLE
//   overflow           out  sticky: a frame arrived while pending was saturated
//   timeout            out  sticky watchdog flag
// -----------------------------------------------------------------------------
module abm_sched #(
  parameter int RING_W         = 4,
  parameter int PEND_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [63:0]       base_addr,
  input  logic [31:0]       stride,
  input  logic [RING_W:0]   ring_slots,
  input  logic              frame_ready,
  output logic              mover_start,
  output logic [63:0]       mover_dst_address,
  input  logic              mover_idle,
  output logic [RING_W-1:0] slot_index,
  output logic [31:0]       frames_done,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_KICK      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state;
  logic              kick_ok;
  logic [RING_W:0]   ring_eff;
  logic [RING_W:0]   slot_inc;
  logic [RING_W-1:0] slot_next;
  logic [63:0]       kick_addr;
  logic              pend_inc;
  logic              pend_dec;
  logic              wd_expire;

  // NOTE: every signal in this always_comb is assigned on every path, so no
  // latch can be inferred; keep it that way when adding outputs here.
  always_comb begin
    kick_ok   = enable && (pending != '0) && (base_addr != '0) && mover_idle;
    ring_eff  = (ring_slots == '0) ? {{RING_W{1'b0}}, 1'b1} : ring_slots;
    // Compare one bit wider than the index so slot 2^RING_W-1 still wraps, and
    // use >= so a ring shrunk below the current slot wraps on the next advance.
    slot_inc  = {1'b0, slot_index} + {{RING_W{1'b0}}, 1'b1};
    slot_next = (slot_inc >= ring_eff) ? '0 : slot_inc[RING_W-1:0];
    // Product is at most RING_W+32 bits, so it is exact in 64 bits; the sum
    // wraps modulo 2^64.
    kick_addr = base_addr + (64'(slot_index) * 64'(stride));
    pend_inc  = frame_ready;
    pend_dec  = (state == S_KICK);
  end

  // Pending-frame counter. A simultaneous arrival and kick cancel out; an
  // arrival at saturation with no kick is dropped and flagged.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (pend_inc && !pend_dec) begin
      if (pending == PEND_MAX) overflow <= 1'b1;
      else                     pending  <= pending + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pending <= pending - PEND_W'(1);
    end
  end

`ifdef ABM_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts cycles in the two wait states; cleared whenever a transfer is not
  // outstanding so every kick starts with a fresh budget.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || state == S_KICK) wd_cnt <= '0;
    else                                             wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_comb begin
    wd_expire = ((state == S_WAIT_BUSY) || (state == S_WAIT_IDLE)) && (wd_cnt == WD_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset)          timeout <= 1'b0;
    else if (wd_expire) timeout <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Main FSM. Outputs are registered alongside the state so mover_start, the
  // destination address and busy line up with the state they describe. The
  // destination is captured on the edge into S_KICK so it is valid during the
  // single cycle mover_start is high; base_addr/stride are sampled only there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      mover_start       <= 1'b0;
      mover_dst_address <= '0;
      slot_index        <= '0;
      frames_done       <= '0;
      busy              <= 1'b0;
    end else begin
      mover_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (kick_ok) begin
            state             <= S_KICK;
            mover_start       <= 1'b1;
            mover_dst_address <= kick_addr;
            busy              <= 1'b1;
          end
        end
        S_KICK: begin
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A timed-out frame is lost: no completion count, no slot advance.
          if (wd_expire) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!mover_idle) begin
            state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (wd_expire) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (mover_idle) begin
            frames_done <= frames_done + 32'd1;
            slot_index  <= slot_next;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abm_sched.sv
// -----------------------------------------------------------------------------
// tb_abm_sched -- self-checking bench for abm_sched
//
// A behavioural mover model answers each kick by dropping idle for a
// configurable number of cycles and logs every kick address. A ring model
// (slot counter + address arithmetic) predicts the address sequence, the
// completion count and the final slot. Scenario tasks are called in order
// from one initial block; the run ends with a single summary line.
// -----------------------------------------------------------------------------
module tb_abm_sched;

  localparam int RING_W = 4;
  localparam int PEND_W = 4;
  localparam int TO_CYC = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [63:0]       base_addr;
  logic [31:0]       stride;
  logic [RING_W:0]   ring_slots;
  logic              frame_ready;
  logic              mover_start;
  logic [63:0]       mover_dst_address;
  logic              mover_idle;
  logic [RING_W-1:0] slot_index;
  logic [31:0]       frames_done;
  logic [PEND_W-1:0] pending;
  logic              busy;
  logic              overflow;
  logic              timeout;

  abm_sched #(
    .RING_W        (RING_W),
    .PEND_W        (PEND_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .base_addr        (base_addr),
    .stride           (stride),
    .ring_slots       (ring_slots),
    .frame_ready      (frame_ready),
    .mover_start      (mover_start),
    .mover_dst_address(mover_dst_address),
    .mover_idle       (mover_idle),
    .slot_index       (slot_index),
    .frames_done      (frames_done),
    .pending          (pending),
    .busy             (busy),
    .overflow         (overflow),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Mover model controls and kick log.
  int          mover_lat  = 4;
  logic        mover_hang = 1'b0;
  logic [63:0] obs_q[$];

  // Ring model.
  logic [63:0] m_base;
  logic [31:0] m_stride;
  int          m_ring;
  int          m_slot;
  int          m_done;

  function automatic int ring_eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  // Next expected kick address; advances the model's slot and completion count.
  function automatic logic [63:0] model_next_addr();
    logic [63:0] a;
    a      = m_base + (64'(m_slot) * 64'(m_stride));
    m_slot = (m_slot + 1 >= ring_eff(m_ring)) ? 0 : m_slot + 1;
    m_done = m_done + 1;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [63:0] b, input logic [31:0] s, input int r);
    m_base     = b;
    m_stride   = s;
    m_ring     = r;
    base_addr  = b;
    stride     = s;
    ring_slots = (RING_W + 1)'(r);
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  // Mover model: idle drops in the kick cycle and returns after mover_lat
  // cycles (never, while mover_hang is set). Also watches the kick protocol.
  initial begin : mover_model
    int   cnt;
    logic prev_start;
    cnt        = 0;
    prev_start = 1'b0;
    mover_idle = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cnt        = 0;
        mover_idle = 1'b1;
        prev_start = 1'b0;
      end else begin
        if (mover_start) begin
          obs_q.push_back(mover_dst_address);
          checks++;
          if (prev_start) begin
            errors++;
            $display("FAIL start_back_to_back mover_start high in two consecutive cycles at %0t", $time);
          end
          checks++;
          if (mover_idle !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy mover_idle=%b required 1 at kick, time %0t", mover_idle, $time);
          end
          mover_idle = 1'b0;
          cnt        = mover_lat;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !mover_hang) mover_idle = 1'b1;
        end else if (!mover_hang) begin
          mover_idle = 1'b1;
        end
        prev_start = mover_start;
      end
    end
  end

  // Waits until n kicks are logged and the FSM is back in idle, then confirms
  // no extra kicks follow.
  task automatic wait_kicks(input int n, input string name);
    int cyc;
    cyc = 0;
    while ((obs_q.size() < n || busy) && cyc < 4000) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s_wait kicks=%0d busy=%b required kicks=%0d busy=0 within 4000 cycles", name, obs_q.size(), busy, n);
    end
    repeat (20) step();
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL %s_kick_count got %0d required %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    frame_ready = 1'b0;
    set_cfg(64'd0, 32'd0, 0);
    repeat (3) step();
    checks++; if (mover_start !== 1'b0)       begin errors++; $display("FAIL reset_start got %b required 0", mover_start); end
    checks++; if (mover_dst_address !== 64'd0) begin errors++; $display("FAIL reset_dst got %h required 0", mover_dst_address); end
    checks++; if (slot_index !== '0)          begin errors++; $display("FAIL reset_slot got %0d required 0", slot_index); end
    checks++; if (frames_done !== 32'd0)      begin errors++; $display("FAIL reset_done got %0d required 0", frames_done); end
    checks++; if (pending !== '0)             begin errors++; $display("FAIL reset_pending got %0d required 0", pending); end
    checks++; if (busy !== 1'b0)              begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (overflow !== 1'b0)          begin errors++; $display("FAIL reset_overflow got %b required 0", overflow); end
    checks++; if (timeout !== 1'b0)           begin errors++; $display("FAIL reset_timeout got %b required 0", timeout); end
    reset  = 1'b0;
    m_slot = 0;
    m_done = 0;
    step();
  endtask

  task automatic test_basic_ring();
    logic [63:0] exp;
    logic [63:0] got;
    set_cfg(64'h1_0000_0000, 32'h0010_0000, 4);
    mover_lat = 20;
    enable    = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      pulse_frame();
      repeat ($urandom_range(0, 5)) step();
    end
    wait_kicks(6, "basic");
    for (int i = 0; i < 6; i++) begin
      exp = model_next_addr();
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_addr[%0d] got %h required %h", i, got, exp); end
    end
    checks++; if (frames_done !== 32'(m_done))     begin errors++; $display("FAIL basic_done got %0d required %0d", frames_done, m_done); end
    checks++; if (slot_index !== RING_W'(m_slot))  begin errors++; $display("FAIL basic_slot got %0d required %0d", slot_index, m_slot); end
    checks++; if (pending !== '0)                  begin errors++; $display("FAIL basic_pending got %0d required 0", pending); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    logic [63:0] got;
    // Base near the top of the address space so slot offsets wrap mod 2^64.
    set_cfg(64'hFFFF_FFFF_FFFF_0000 | 64'($urandom_range(1, 16'hFFFF)), $urandom, $urandom_range(1, 16));
    enable = 1'b0;
    obs_q.delete();
    frame_ready = 1'b1;
    repeat (16) step();
    frame_ready = 1'b0;
    repeat (5) step();
    checks++; if (pending !== PEND_W'(15)) begin errors++; $display("FAIL ovf_pending got %0d required 15", pending); end
    checks++; if (overflow !== 1'b1)       begin errors++; $display("FAIL ovf_flag got %b required 1", overflow); end
    checks++; if (obs_q.size() != 0)       begin errors++; $display("FAIL ovf_no_kick got %0d kicks required 0", obs_q.size()); end
    mover_lat = $urandom_range(2, 8);
    enable    = 1'b1;
    wait_kicks(15, "ovf");
    for (int i = 0; i < 15; i++) begin
      exp = model_next_addr();
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ovf_addr[%0d] got %h required %h", i, got, exp); end
    end
    checks++; if (frames_done !== 32'(m_done)) begin errors++; $display("FAIL ovf_done got %0d required %0d", frames_done, m_done); end
    checks++; if (overflow !== 1'b1)           begin errors++; $display("FAIL ovf_sticky got %b required 1", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] exp;
    logic [63:0] got;
    set_cfg({$urandom, $urandom} | 64'h1, $urandom, $urandom_range(1, 16));
    mover_lat = 6;
    enable    = 1'b1;
    obs_q.delete();
    frame_ready = 1'b1;                 // cycle N
    step();
    frame_ready = 1'b0;                 // cycle N+1
    checks++; if (pending !== PEND_W'(1)) begin errors++; $display("FAIL sim_pending_n1 got %0d required 1", pending); end
    checks++; if (mover_start !== 1'b0)   begin errors++; $display("FAIL sim_start_n1 got %b required 0", mover_start); end
    step();                             // cycle N+2: kick, plus a new frame
    checks++; if (mover_start !== 1'b1)   begin errors++; $display("FAIL sim_start_n2 got %b required 1", mover_start); end
    frame_ready = 1'b1;
    step();                             // cycle N+3
    frame_ready = 1'b0;
    checks++; if (pending !== PEND_W'(1)) begin errors++; $display("FAIL sim_pending_n3 got %0d required 1", pending); end
    checks++; if (mover_start !== 1'b0)   begin errors++; $display("FAIL sim_start_n3 got %b required 0", mover_start); end
    wait_kicks(2, "sim");
    for (int i = 0; i < 2; i++) begin
      exp = model_next_addr();
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sim_addr[%0d] got %h required %h", i, got, exp); end
    end
    checks++; if (pending !== '0) begin errors++; $display("FAIL sim_pending_end got %0d required 0", pending); end
  endtask

  task automatic test_gating();
    logic [63:0] exp;
    logic [63:0] got;
    set_cfg(64'd0, $urandom, $urandom_range(1, 16));
    enable    = 1'b1;
    mover_lat = 3;
    obs_q.delete();
    repeat (3) begin
      pulse_frame();
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (40) step();
    checks++; if (obs_q.size() != 0)      begin errors++; $display("FAIL gate_no_kick got %0d kicks required 0", obs_q.size()); end
    checks++; if (pending !== PEND_W'(3)) begin errors++; $display("FAIL gate_pending got %0d required 3", pending); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL gate_busy got %b required 0", busy); end
    set_cfg(64'h2000, m_stride, m_ring);
    wait_kicks(3, "gate");
    for (int i = 0; i < 3; i++) begin
      exp = model_next_addr();
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL gate_addr[%0d] got %h required %h", i, got, exp); end
    end
  endtask

  task automatic test_random();
    logic [63:0] exp;
    logic [63:0] got;
    for (int r = 0; r < 4; r++) begin
      // ring_slots = 0 is allowed here and must behave as a one-slot ring.
      set_cfg({$urandom, $urandom} | 64'h1, $urandom, $urandom_range(0, 16));
      mover_lat = $urandom_range(2, 12);
      obs_q.delete();
      for (int f = 0; f < 8; f++) begin
        enable = ($urandom_range(0, 3) != 0);
        pulse_frame();
        repeat ($urandom_range(0, 25)) step();
      end
      enable = 1'b1;
      wait_kicks(8, "rand");
      for (int i = 0; i < 8; i++) begin
        exp = model_next_addr();
        got = (i < obs_q.size()) ? obs_q[i] : 'x;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand%0d_addr[%0d] got %h required %h", r, i, got, exp); end
      end
      checks++; if (frames_done !== 32'(m_done))    begin errors++; $display("FAIL rand%0d_done got %0d required %0d", r, frames_done, m_done); end
      checks++; if (slot_index !== RING_W'(m_slot)) begin errors++; $display("FAIL rand%0d_slot got %0d required %0d", r, slot_index, m_slot); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_cfg(64'h4000, 32'h100, 8);
    mover_lat = 30;
    enable    = 1'b1;
    pulse_frame();
    cyc = 0;
    while (!mover_start && cyc < 20) begin step(); cyc++; end
    checks++; if (cyc >= 20) begin errors++; $display("FAIL rstmid_kick no kick seen within 20 cycles"); end
    repeat (5) step();                  // now waiting for the mover to finish
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rstmid_busy_before got %b required 1", busy); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rstmid_ovf_before got %b required 1", overflow); end
    reset = 1'b1;
    step();
    checks++; if (mover_start !== 1'b0)        begin errors++; $display("FAIL rstmid_start got %b required 0", mover_start); end
    checks++; if (mover_dst_address !== 64'd0) begin errors++; $display("FAIL rstmid_dst got %h required 0", mover_dst_address); end
    checks++; if (slot_index !== '0)           begin errors++; $display("FAIL rstmid_slot got %0d required 0", slot_index); end
    checks++; if (frames_done !== 32'd0)       begin errors++; $display("FAIL rstmid_done got %0d required 0", frames_done); end
    checks++; if (pending !== '0)              begin errors++; $display("FAIL rstmid_pending got %0d required 0", pending); end
    checks++; if (busy !== 1'b0)               begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
    checks++; if (overflow !== 1'b0)           begin errors++; $display("FAIL rstmid_overflow got %b required 0", overflow); end
    checks++; if (timeout !== 1'b0)            begin errors++; $display("FAIL rstmid_timeout got %b required 0", timeout); end
    step();
    reset  = 1'b0;
    m_slot = 0;
    m_done = 0;
    obs_q.delete();
    repeat (10) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_kick got %0d kicks required 0", obs_q.size()); end
  endtask

  task automatic test_timeout();
`ifdef ABM_SCHED_TIMEOUT_EN
    logic [63:0] exp;
    logic [63:0] got;
    int          cyc;
    logic [31:0] done0;
    set_cfg(64'h8000, 32'h40, 5);
    mover_lat  = 2;
    mover_hang = 1'b1;
    enable     = 1'b1;
    done0      = frames_done;
    obs_q.delete();
    pulse_frame();
    cyc = 0;
    while (!mover_start && cyc < 20) begin step(); cyc++; end
    checks++; if (cyc >= 20) begin errors++; $display("FAIL to_kick no kick seen within 20 cycles"); end
    cyc = 0;
    while (busy && cyc < 500) begin step(); cyc++; end
    // Kick cycle, then TO_CYC wait cycles, then idle.
    checks++; if (cyc != TO_CYC + 1)         begin errors++; $display("FAIL to_latency busy fell after %0d cycles required %0d", cyc, TO_CYC + 1); end
    checks++; if (timeout !== 1'b1)          begin errors++; $display("FAIL to_flag got %b required 1", timeout); end
    checks++; if (frames_done !== done0)     begin errors++; $display("FAIL to_done got %0d required %0d", frames_done, done0); end
    checks++; if (slot_index !== RING_W'(m_slot)) begin errors++; $display("FAIL to_slot got %0d required %0d", slot_index, m_slot); end
    checks++; if (pending !== '0)            begin errors++; $display("FAIL to_pending got %0d required 0", pending); end
    mover_hang = 1'b0;
    repeat (3) step();
    obs_q.delete();
    pulse_frame();
    wait_kicks(1, "to_after");
    exp = model_next_addr();
    got = (obs_q.size() > 0) ? obs_q[0] : 'x;
    checks++; if (got !== exp)       begin errors++; $display("FAIL to_after_addr got %h required %h", got, exp); end
    checks++; if (timeout !== 1'b1)  begin errors++; $display("FAIL to_sticky got %b required 1", timeout); end
`else
    repeat (5) step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_tied got %b required 0", timeout); end
`endif
  endtask

  initial begin : global_limit
    #900_000;
    $display("FAIL global_time_limit simulation did not finish by %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic_ring();
    test_overflow();
    test_simultaneous();
    test_gating();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
